burst_feeder: RTL

Source side of the go/byte-burst accumulator interface. The block is loaded with a burst of bytes and, on start, issues a one-cycle `go` pulse followed by the bytes on consecutive cycles. It then waits for the accumulator's `valid`/sum result and compares it against its own running sum. It sits between the test or control logic and the accumulator, and serves both as a stimulus driver and as a self-checking scoreboard.

---
 rtl/burst_feeder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/burst_feeder.sv
// Burst source and result checker for the go/byte-burst accumulator interface.
// Define BURST_FEEDER_REPLAY_EN to keep the buffered burst after DONE so it can be resent.
module burst_feeder #(
    parameter int BYTES   = 4,
    parameter int SUM_W   = 11,
    parameter int TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       rst_in,
    input  logic                       load_in,
    input  logic [7:0]                 load_data_in,
    input  logic                       start_in,
    output logic                       busy_out,
    output logic                       go_out,
    output logic [7:0]                 d_out,
    input  logic                       valid_in,
    input  logic [SUM_W-1:0]           sum_in,
    output logic                       done_out,
    output logic                       match_out,
    output logic                       timeout_out,
    output logic [$clog2(BYTES+1)-1:0] count_out
);

    localparam int CNT_W  = $clog2(BYTES + 1);
    localparam int IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

`ifdef BURST_FEEDER_REPLAY_EN
    localparam bit REPLAY = 1'b1;
`else
    localparam bit REPLAY = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_GO,
        S_SEND,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SUM_W-1:0]   expSum_q, expSum_d;
    logic [WAIT_W-1:0]  waitCnt_q, waitCnt_d;
    logic               match_q, match_d;
    logic               timeout_q, timeout_d;
    logic               busy_q, busy_d;
    logic               go_q, go_d;
    logic               done_q, done_d;
    logic [7:0]         dOut_q, dOut_d;

    logic [7:0]         buf_q [BYTES];
    logic               bufWe;
    logic [IDX_W-1:0]   bufWaddr;
    logic               full;

    assign full = (count_q == CNT_W'(BYTES));

    // The buffer is not reset: its contents only matter once count reaches BYTES.
    always_ff @(posedge clk) begin
        if (bufWe) begin
            buf_q[bufWaddr] <= load_data_in;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        expSum_d  = expSum_q;
        waitCnt_d = waitCnt_q;
        match_d   = match_q;
        timeout_d = timeout_q;
        bufWe     = 1'b0;
        bufWaddr  = '0;

        case (state_q)
            S_IDLE: begin
                if (start_in && full) begin
                    state_d   = S_GO;
                    idx_d     = '0;
                    expSum_d  = '0;
                    match_d   = 1'b0;
                    timeout_d = 1'b0;
                end else if (load_in) begin
                    bufWe = 1'b1;
                    if (full) begin
                        bufWaddr = '0;
                        count_d  = CNT_W'(1);
                    end else begin
                        bufWaddr = IDX_W'(count_q);
                        count_d  = count_q + CNT_W'(1);
                    end
                end
            end
            S_GO: begin
                idx_d    = '0;
                expSum_d = '0;
                state_d  = S_SEND;
            end
            S_SEND: begin
                expSum_d = expSum_q + SUM_W'(buf_q[idx_q]);
                if (idx_q == IDX_W'(BYTES - 1)) begin
                    state_d   = S_WAIT;
                    waitCnt_d = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_WAIT: begin
                // A result arriving on the expiry cycle still counts as a result.
                if (valid_in) begin
                    match_d = (sum_in == expSum_q);
                    state_d = S_DONE;
                end else if (waitCnt_q == WAIT_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    match_d   = 1'b0;
                    state_d   = S_DONE;
                end else begin
                    waitCnt_d = waitCnt_q + WAIT_W'(1);
                end
                if (!REPLAY && state_d == S_DONE) begin
                    count_d = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they appear registered.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        go_d   = (state_d == S_GO);
        done_d = (state_d == S_DONE);
        dOut_d = (state_d == S_SEND) ? buf_q[idx_d] : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            idx_q     <= '0;
            expSum_q  <= '0;
            waitCnt_q <= '0;
            match_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            go_q      <= 1'b0;
            done_q    <= 1'b0;
            dOut_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            expSum_q  <= expSum_d;
            waitCnt_q <= waitCnt_d;
            match_q   <= match_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            go_q      <= go_d;
            done_q    <= done_d;
            dOut_q    <= dOut_d;
        end
    end

    assign busy_out    = busy_q;
    assign go_out      = go_q;
    assign d_out       = dOut_q;
    assign done_out    = done_q;
    assign match_out   = match_q;
    assign timeout_out = timeout_q;
    assign count_out   = count_q;

endmodule
